// File: rtl/wide_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wide_add_sequencer                                           |
// | Description : Multi-precision add/subtract engine. It computes one SLICE-  |
// |               bit slice per cycle through a shared carry-skip adder.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module wide_add_sequencer_csa #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int c_blocks = WIDTH / 4;

  logic [4:0] w_blk;
  logic       w_carry;

  // 4-bit ripple blocks; a fully propagating block passes its carry-in straight through.
  always_comb begin
    w_blk   = '0;
    w_carry = cin;
    sum     = '0;
    for (int i = 0; i < c_blocks; i++) begin
      w_blk = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0000, w_carry};
      sum[i*4 +: 4] = w_blk[3:0];
      w_carry = (&(a[i*4 +: 4] ^ b[i*4 +: 4])) ? w_carry : w_blk[4];
    end
    cout     = w_carry;
    overflow = (a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1]) ^ w_carry;
  end

endmodule

module wide_add_sequencer #(
  parameter int SLICE  = 32,
  parameter int SLICES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLICE*SLICES-1:0] a,
  input  logic [SLICE*SLICES-1:0] b,
  input  logic                    cin,
  input  logic                    op_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SLICE*SLICES-1:0] sum,
  output logic                    cout,
  output logic                    overflow
);

  localparam int W    = SLICE * SLICES;
  localparam int IDXW = ($clog2(SLICES) < 1) ? 1 : $clog2(SLICES);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [IDXW-1:0] c_last = IDXW'(SLICES - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic [IDXW-1:0] r_idx;

  logic [SLICE-1:0] w_csa_sum;
  logic             w_csa_cout;
  logic             w_csa_ovf;

  wide_add_sequencer_csa #(
    .WIDTH (SLICE)
  ) u_csa (
    .a        (r_a[r_idx*SLICE +: SLICE]),
    .b        (r_b[r_idx*SLICE +: SLICE]),
    .cin      (r_carry),
    .sum      (w_csa_sum),
    .cout     (w_csa_cout),
    .overflow (w_csa_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (in_valid) w_state_nxt = c_run;
      c_run:   if (r_idx == c_last) w_state_nxt = c_done;
      c_done:  if (out_ready) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_idle);
    out_valid = (r_state == c_done);
  end

  // Subtraction is folded into the add: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == c_idle) begin
      if (in_valid) begin
        r_a     <= a;
        r_b     <= op_sub ? ~b : b;
        r_carry <= op_sub | cin;
        r_idx   <= '0;
      end
    end else if (r_state == c_run) begin
      r_sum[r_idx*SLICE +: SLICE] <= w_csa_sum;
      r_carry                     <= w_csa_cout;
      if (r_idx == c_last) begin
        r_cout <= w_csa_cout;
        r_ovf  <= w_csa_ovf;
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wide_add_sequencer                                        |
// | Description : Directed and randomized checks of wide_add_sequencer against |
// |               an arithmetic reference model.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_wide_add_sequencer;

  localparam int SLICE  = 32;
  localparam int SLICES = 4;
  localparam int W      = SLICE * SLICES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int vectors    = 0;
  int miscompares = 0;

  wide_add_sequencer #(
    .SLICE  (SLICE),
    .SLICES (SLICES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: unsigned arithmetic for sum/carry, operand signs for overflow.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic sub, output logic [W-1:0] s, output logic co,
                       output logic ov);
    logic [W:0] t;
    if (sub) begin
      s  = x - y;
      co = (x >= y);
      ov = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    end else begin
      t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      s  = t[W-1:0];
      co = t[W];
      ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                       input logic tsub, input int stall);
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
    int           n;
    model(ta, tb, tcin, tsub, esum, ecout, eovf);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {127'd0, in_ready}, 1);
    a = ta; b = tb; cin = tcin; op_sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rnd(); b = rnd(); cin = 1'($urandom()); op_sub = 1'($urandom());
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", W'(n), W'(SLICES));
    check("sum", sum, esum);
    check("cout", {127'd0, cout}, {127'd0, ecout});
    check("overflow", {127'd0, overflow}, {127'd0, eovf});
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom());
      a = rnd(); b = rnd();
      @(posedge clk); #1;
      check("stall_valid", {127'd0, out_valid}, 1);
      check("stall_ready", {127'd0, in_ready}, 0);
      check("stall_sum", sum, esum);
      check("stall_cout", {127'd0, cout}, {127'd0, ecout});
      check("stall_ovf", {127'd0, overflow}, {127'd0, eovf});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", {127'd0, out_valid}, 0);
    check("release_ready", {127'd0, in_ready}, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {127'd0, in_ready}, 1);
    check("rst_out_valid", {127'd0, out_valid}, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", {127'd0, cout}, 0);
    check("rst_ovf", {127'd0, overflow}, 0);

    // Carry ripples through every slice.
    do_op({W{1'b1}}, 1, 1'b0, 1'b0, 0);
    check("allones_sum_const", sum, 0);
    // Signed overflow into the sign bit.
    do_op({1'b0, {(W-1){1'b1}}}, 1, 1'b0, 1'b0, 0);
    // Subtract with borrow; cin must be ignored.
    do_op(5, 7, 1'b1, 1'b1, 0);
    do_op(7, 5, 1'b1, 1'b1, 0);
    // Backpressure followed by a back-to-back request.
    do_op(rnd(), rnd(), 1'b1, 1'b0, 10);
    do_op(rnd(), rnd(), 1'b0, 1'b1, 0);

    // Reset during the second RUN cycle discards the operation.
    a = {W{1'b1}}; b = 1; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {127'd0, out_valid}, 0);
    check("midrst_sum", sum, 0);
    check("midrst_in_ready", {127'd0, in_ready}, 1);
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    for (int i = 0; i < SLICES + 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_result", {127'd0, out_valid}, 0);
    end
    do_op(3, 4, 1'b0, 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      do_op(rnd(), rnd(), 1'($urandom()), 1'($urandom()), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
